// File: rtl/bus_arb_pkg.sv
// Shared constants, state encoding and helpers for the 8-way round-robin bus arbiter.
package bus_arb_pkg;

  localparam int N_REQ = 8;
  localparam int SEL_W = 3;
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
    logic [N_REQ-1:0] one;
    one = {{(N_REQ-1){1'b0}}, 1'b1};
    return one << idx;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request scanning circularly from ptr+1.
module rr_pick
  import bus_arb_pkg::*;
(
  input  logic [N_REQ-1:0] i_req,
  input  logic [SEL_W-1:0] i_ptr,
  output logic             o_valid,
  output logic [SEL_W-1:0] o_idx
);

  logic [N_REQ-1:0] w_rot;
  logic [SEL_W-1:0] w_off;

  // Rotate so that bit 0 corresponds to requester ptr+1 (3-bit wrap).
  always_comb begin
    w_rot = {N_REQ{1'b0}};
    for (int k = 0; k < N_REQ; k++) begin
      w_rot[k] = i_req[i_ptr + SEL_W'(k + 1)];
    end
  end

  // Priority-encode the lowest set bit of the rotated vector.
  always_comb begin
    w_off = {SEL_W{1'b0}};
    for (int k = N_REQ - 1; k >= 0; k--) begin
      w_off = w_rot[k] ? SEL_W'(k) : w_off;
    end
  end

  assign o_valid = |i_req;
  assign o_idx   = i_ptr + w_off + SEL_W'(1);

endmodule

// File: rtl/bus_arbiter_8.sv
// Round-robin owner FSM for the 16-bit internal bus: bounded hold, lock override,
// and a one-cycle dead gap between owners. All outputs are registered.
module bus_arbiter_8
  import bus_arb_pkg::*;
#(
  parameter int MAX_HOLD = 15
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [N_REQ-1:0] i_req,
  input  logic             i_lock,
  output logic [N_REQ-1:0] o_gnt,
  output logic [SEL_W-1:0] o_sel,
  output logic             o_en,
  output logic             o_busy
);

  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);

  state_t           r_state, w_state_nxt;
  logic [SEL_W-1:0] r_ptr, w_ptr_nxt;
  logic [SEL_W-1:0] r_sel, w_sel_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [N_REQ-1:0] r_gnt, w_gnt_nxt;
  logic             r_en, w_en_nxt;
  logic             r_busy, w_busy_nxt;
  logic             w_valid;
  logic [SEL_W-1:0] w_idx;
  logic             w_release;

  rr_pick u_pick (
    .i_req   (i_req),
    .i_ptr   (r_ptr),
    .o_valid (w_valid),
    .o_idx   (w_idx)
  );

  // >= so that LOCK falling after saturation releases on that same cycle.
  assign w_release = !i_req[r_sel] || ((r_cnt >= HOLD_MAX) && !i_lock);

  // Next-state, pointer, hold counter and next output values.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_cnt_nxt   = r_cnt;
    w_sel_nxt   = r_sel;
    w_gnt_nxt   = {N_REQ{1'b0}};
    w_en_nxt    = 1'b0;
    w_busy_nxt  = 1'b0;
    case (r_state)
      ST_IDLE, ST_GAP: begin
        if (w_valid) begin
          w_state_nxt = ST_GRANT;
          w_ptr_nxt   = w_idx;
          w_cnt_nxt   = CNT_W'(1);
          w_sel_nxt   = w_idx;
          w_gnt_nxt   = onehot(w_idx);
          w_en_nxt    = 1'b1;
          w_busy_nxt  = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = {CNT_W{1'b0}};
        end
      end
      ST_GRANT: begin
        if (w_release) begin
          w_state_nxt = ST_GAP;
          w_cnt_nxt   = {CNT_W{1'b0}};
        end else begin
          w_state_nxt = ST_GRANT;
          w_gnt_nxt   = r_gnt;
          w_en_nxt    = 1'b1;
          w_busy_nxt  = 1'b1;
          w_cnt_nxt   = (r_cnt < HOLD_MAX) ? (r_cnt + CNT_W'(1)) : r_cnt;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = {CNT_W{1'b0}};
      end
    endcase
  end

  // State, pointer, counter and output registers; PTR resets to 7 so the first scan starts at 0.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_ptr   <= {SEL_W{1'b1}};
      r_cnt   <= {CNT_W{1'b0}};
      r_sel   <= {SEL_W{1'b0}};
      r_gnt   <= {N_REQ{1'b0}};
      r_en    <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_cnt   <= w_cnt_nxt;
      r_sel   <= w_sel_nxt;
      r_gnt   <= w_gnt_nxt;
      r_en    <= w_en_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  assign o_gnt  = r_gnt;
  assign o_sel  = r_sel;
  assign o_en   = r_en;
  assign o_busy = r_busy;

endmodule

// File: tb/tb_bus_arbiter_8.sv
// Directed bench for bus_arbiter_8 with hand-computed expected grant sequences.
module tb_bus_arbiter_8;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic       lock;
  logic [7:0] gnt;
  logic [2:0] sel;
  logic       en;
  logic       busy;

  int n_pass;
  int n_total;

  bus_arbiter_8 #(.MAX_HOLD(15)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_req   (req),
    .i_lock  (lock),
    .o_gnt   (gnt),
    .o_sel   (sel),
    .o_en    (en),
    .o_busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] oh(input int i);
    logic [7:0] one;
    one = 8'h01;
    return one << i;
  endfunction

  task automatic chk(input string tag, input logic [7:0] eg, input logic [2:0] es,
                     input logic ee, input logic eb);
    logic [12:0] o_vec;
    logic [12:0] e_vec;
    o_vec = {gnt, sel, en, busy};
    e_vec = {eg, es, ee, eb};
    n_total++;
    assert (o_vec === e_vec) n_pass++;
    else $error("FAIL %s: got gnt=%h sel=%0d en=%b busy=%b, expected gnt=%h sel=%0d en=%b busy=%b",
                tag, gnt, sel, en, busy, eg, es, ee, eb);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 8'h00;
    lock  = 1'b0;
    #1;
    chk("reset", 8'h00, 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst_n   = 1'b0;
    req     = 8'h00;
    lock    = 1'b0;
    #2;
    chk("por", 8'h00, 3'd0, 1'b0, 1'b0);

    // 1: single request, drop, gap then idle
    do_reset();
    req = 8'h01;
    step(1);
    chk("t1_grant", 8'h01, 3'd0, 1'b1, 1'b1);
    req = 8'h00;
    step(1);
    chk("t1_gap", 8'h00, 3'd0, 1'b0, 1'b0);
    step(1);
    chk("t1_idle", 8'h00, 3'd0, 1'b0, 1'b0);

    // 2: all requesting, rotation 0..7,0 with 15-cycle holds and one gap each
    do_reset();
    req = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      step(1);
      chk($sformatf("t2_first_%0d", k), oh(k % 8), 3'(k % 8), 1'b1, 1'b1);
      step(14);
      chk($sformatf("t2_last_%0d", k), oh(k % 8), 3'(k % 8), 1'b1, 1'b1);
      step(1);
      chk($sformatf("t2_gap_%0d", k), 8'h00, 3'(k % 8), 1'b0, 1'b0);
    end

    // 3: lone requester 4 is forced off every 15 cycles and re-granted
    do_reset();
    req = 8'h10;
    step(1);
    chk("t3_grant", 8'h10, 3'd4, 1'b1, 1'b1);
    for (int k = 0; k < 2; k++) begin
      step(14);
      chk($sformatf("t3_hold_%0d", k), 8'h10, 3'd4, 1'b1, 1'b1);
      step(1);
      chk($sformatf("t3_gap_%0d", k), 8'h00, 3'd4, 1'b0, 1'b0);
      step(1);
      chk($sformatf("t3_regrant_%0d", k), 8'h10, 3'd4, 1'b1, 1'b1);
    end

    // 4: lock holds requester 2 for 30 cycles, unlock hands over to 5
    do_reset();
    req  = 8'h24;
    lock = 1'b1;
    step(1);
    chk("t4_grant", 8'h04, 3'd2, 1'b1, 1'b1);
    step(15);
    chk("t4_locked16", 8'h04, 3'd2, 1'b1, 1'b1);
    step(14);
    chk("t4_locked30", 8'h04, 3'd2, 1'b1, 1'b1);
    lock = 1'b0;
    step(1);
    chk("t4_gap", 8'h00, 3'd2, 1'b0, 1'b0);
    step(1);
    chk("t4_next", 8'h20, 3'd5, 1'b1, 1'b1);

    // 5: owner 3 drops exactly at cnt==15 with requester 0 pending
    do_reset();
    req = 8'h08;
    step(1);
    chk("t5_grant", 8'h08, 3'd3, 1'b1, 1'b1);
    req = 8'h09;
    step(14);
    chk("t5_hold", 8'h08, 3'd3, 1'b1, 1'b1);
    req = 8'h01;
    step(1);
    chk("t5_gap", 8'h00, 3'd3, 1'b0, 1'b0);
    step(1);
    chk("t5_next", 8'h01, 3'd0, 1'b1, 1'b1);
    step(1);
    chk("t5_stay", 8'h01, 3'd0, 1'b1, 1'b1);

    // 6: async reset mid-grant, PTR back to 7
    do_reset();
    req = 8'h40;
    step(1);
    chk("t6_grant", 8'h40, 3'd6, 1'b1, 1'b1);
    step(3);
    rst_n = 1'b0;
    #1;
    chk("t6_async_rst", 8'h00, 3'd0, 1'b0, 1'b0);
    req = 8'hC0;
    @(negedge clk);
    rst_n = 1'b1;
    step(1);
    chk("t6_after_rst", 8'h40, 3'd6, 1'b1, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
